sigdel_dac: RTL

First-order digital sigma-delta DAC modulator: the transmit-side counterpart of the passive sigma-delta ADC. It accepts parallel unsigned samples through a valid/ready handshake and holds them in a one-entry buffer. Each sample is played out as a 1-bit density stream at a selectable modulator rate and oversampling ratio. The stream drives a pin through an external RC low-pass. The block sits between sample producers (filter outputs, test pattern generators) and the analog pin pair.

---
 rtl/sigdel_pkg.sv | 46 ++++
 rtl/sigdel_dac_mod.sv | 101 ++++++++++
 rtl/sigdel_dac.sv | 94 +++++++++
 3 files changed

// File: rtl/sigdel_pkg.sv
// Shared constants for the sigma-delta DAC: default sample width, OSR terminal
// counts and prescaler tap masks.
package sigdel_pkg;

    localparam int SIGDEL_W  = 10;
    localparam int OSR_CNT_W = 12;
    localparam int PRE_W     = 8;

    typedef logic [SIGDEL_W-1:0] sample_t;

    // OSR counter terminal values (steps per sample minus one)
    localparam logic [OSR_CNT_W-1:0] OSR_TC_16   = 12'd15;
    localparam logic [OSR_CNT_W-1:0] OSR_TC_256  = 12'd255;
    localparam logic [OSR_CNT_W-1:0] OSR_TC_1024 = 12'd1023;
    localparam logic [OSR_CNT_W-1:0] OSR_TC_4096 = 12'd4095;

    // Prescaler taps: mod_en fires when all masked bits are ones.
    // An empty mask gives an enable on every clk.
    localparam logic [PRE_W-1:0] PRE_MASK_1   = 8'h00;
    localparam logic [PRE_W-1:0] PRE_MASK_4   = 8'h03;
    localparam logic [PRE_W-1:0] PRE_MASK_16  = 8'h0F;
    localparam logic [PRE_W-1:0] PRE_MASK_256 = 8'hFF;

    function automatic logic [OSR_CNT_W-1:0] osr_tc(input logic [1:0] sel);
        logic [OSR_CNT_W-1:0] tc;
        case (sel)
            2'd0:    tc = OSR_TC_16;
            2'd1:    tc = OSR_TC_256;
            2'd2:    tc = OSR_TC_1024;
            default: tc = OSR_TC_4096;
        endcase
        return tc;
    endfunction

    function automatic logic [PRE_W-1:0] pre_mask(input logic [1:0] sel);
        logic [PRE_W-1:0] m;
        case (sel)
            2'd0:    m = PRE_MASK_1;
            2'd1:    m = PRE_MASK_4;
            2'd2:    m = PRE_MASK_16;
            default: m = PRE_MASK_256;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sigdel_dac_mod.sv
// Sigma-delta modulator core. Steps once per enable and registers one output bit.
// SIGDEL_DAC_ORDER2_EN selects a saturating second-order loop; otherwise a
// first-order carry-out accumulator.
module sigdel_dac_mod
    import sigdel_pkg::*;
#(
    parameter int W     = SIGDEL_W,
    parameter int ACC_W = SIGDEL_W + 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] sample,
    output logic         bit_out
);

    // Integrators need at least two bits of headroom over the centered input.
    if (ACC_W < W + 2) begin : g_acc_w_check
        $error("sigdel_dac_mod: ACC_W must be at least W+2");
    end

    logic dout_q, dout_d;

`ifdef SIGDEL_DAC_ORDER2_EN
    // Two extra bits keep the pre-saturation sums exact.
    localparam int E = ACC_W + 2;
    localparam logic signed [E-1:0] HALF    = E'(2 ** (W - 1));
    localparam logic signed [E-1:0] SAT_MAX = E'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [E-1:0] SAT_MIN = -SAT_MAX;

    logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i1_n, i2_n;
    logic signed [E-1:0]     xc, fb, s1, s2;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [E-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > SAT_MAX)      r = SAT_MAX[ACC_W-1:0];
        else if (v < SAT_MIN) r = SAT_MIN[ACC_W-1:0];
        else                  r = v[ACC_W-1:0];
        return r;
    endfunction

    // Loop update: both integrators subtract the previous output bit's feedback.
    always_comb begin
        xc     = $signed({{(E-W){1'b0}}, sample}) - HALF;
        fb     = dout_q ? HALF : -HALF;
        s1     = $signed({{2{i1_q[ACC_W-1]}}, i1_q}) + xc - fb;
        i1_n   = sat(s1);
        s2     = $signed({{2{i2_q[ACC_W-1]}}, i2_q}) + $signed({{2{i1_n[ACC_W-1]}}, i1_n}) - fb;
        i2_n   = sat(s2);
        i1_d   = i1_q;
        i2_d   = i2_q;
        dout_d = dout_q;
        if (en) begin
            i1_d   = i1_n;
            i2_d   = i2_n;
            dout_d = ~i2_n[ACC_W-1];
        end
    end

    // Integrator and output bit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dout_q <= dout_d;
        end
    end
`else
    logic [W-1:0] acc_q, acc_d;
    logic [W:0]   sum;

    // First-order step: the carry out of acc + sample is the output bit.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, sample};
        acc_d  = acc_q;
        dout_d = dout_q;
        if (en) begin
            acc_d  = sum[W-1:0];
            dout_d = sum[W];
        end
    end

    // Accumulator and output bit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end
`endif

    assign bit_out = dout_q;

endmodule

// File: rtl/sigdel_dac.sv
// Sigma-delta DAC top: prescaler, OSR sample-boundary counter, one-entry input
// buffer with valid/ready, and the modulator core.
// Build option: SIGDEL_DAC_ORDER2_EN selects the second-order modulator.
module sigdel_dac
    import sigdel_pkg::*;
#(
    parameter int W     = SIGDEL_W,
    parameter int ACC_W = W + 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [1:0]   rate_sel,
    input  logic [1:0]   osr_sel,
    output logic         dout,
    output logic         dout_n,
    output logic         sample_tick,
    output logic         underrun
);

    logic [PRE_W-1:0]     pre_q, pre_d, mask;
    logic [OSR_CNT_W-1:0] osr_cnt_q, osr_cnt_d, osr_tc_q, osr_tc_d;
    logic                 full_q, full_d;
    logic [W-1:0]         buf_q, buf_d, active_q, active_d;
    logic                 tick_q, tick_d, underrun_q, underrun_d;
    logic                 mod_en, bnd, accept, consume;

    // Enable generation, sample boundary detection and buffer handshake.
    always_comb begin
        mask    = pre_mask(rate_sel);
        mod_en  = (pre_q & mask) == mask;
        bnd     = mod_en && (osr_cnt_q == osr_tc_q);
        // Boundary and accept both look at the pre-edge full flag: no bypass.
        accept  = din_valid && !full_q;
        consume = bnd && full_q;

        pre_d     = pre_q + 1'b1;
        osr_cnt_d = osr_cnt_q;
        if (bnd)         osr_cnt_d = '0;
        else if (mod_en) osr_cnt_d = osr_cnt_q + 1'b1;
        // A new OSR is only picked up at a boundary so periods never truncate.
        osr_tc_d  = bnd ? osr_tc(osr_sel) : osr_tc_q;

        full_d = full_q;
        if (consume)     full_d = 1'b0;
        else if (accept) full_d = 1'b1;
        buf_d      = accept ? din : buf_q;
        active_d   = consume ? buf_q : active_q;
        tick_d     = consume;
        underrun_d = underrun_q | (bnd & ~full_q);
    end

    // Control and datapath registers; the first OSR follows osr_sel held during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            osr_cnt_q  <= '0;
            osr_tc_q   <= osr_tc(osr_sel);
            full_q     <= 1'b0;
            buf_q      <= '0;
            active_q   <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            osr_cnt_q  <= osr_cnt_d;
            osr_tc_q   <= osr_tc_d;
            full_q     <= full_d;
            buf_q      <= buf_d;
            active_q   <= active_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    sigdel_dac_mod #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mod (
        .clk     (clk),
        .rst     (rst),
        .en      (mod_en),
        .sample  (active_q),
        .bit_out (dout)
    );

    assign dout_n      = ~dout;
    assign din_ready   = ~full_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;

endmodule
